// File: rtl/xbus_arbiter_pkg.sv
// Shared definitions for the picoVersat data-bus arbiter: default widths,
// arbitration mode codes and the arbiter FSM state encoding.
package xbus_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_CAPT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/xbus_arbiter_pick.sv
// Combinational 2-way picker: chooses which masked request wins the bus,
// either alternating against the last owner or favouring master 0.
module xarb_pick
    import xbus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       mode_fixed,
    output logic       grant_valid,
    output logic       grant_id
);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11)
            grant_id = mode_fixed ? 1'b0 : ~last_owner;
        else if (req == 2'b10)
            grant_id = 1'b1;
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master arbiter for the picoVersat data bus: serialises one registered
// bus transaction at a time and returns read data plus a one-cycle ack.
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PRIO_MODE = ARB_RR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              bus_sel,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    localparam logic MODE_FIXED = (PRIO_MODE == ARB_FIXED);

    arb_state_e state;
    logic       owner;
    logic       last_owner;
    logic       grant_valid;
    logic       grant_id;

    // A master is ignored in its own ack cycle so a still-high req is not re-granted.
    xarb_pick u_pick (
        .req         ({req1 & ~ack1, req0 & ~ack0}),
        .last_owner  (last_owner),
        .mode_fixed  (MODE_FIXED),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            bus_sel    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        state     <= ARB_BUS;
                        owner     <= grant_id;
                        bus_sel   <= 1'b1;
                        busy      <= 1'b1;
                        bus_we    <= grant_id ? we1    : we0;
                        bus_addr  <= grant_id ? addr1  : addr0;
                        bus_wdata <= grant_id ? wdata1 : wdata0;
                    end
                end
                ARB_BUS: begin
                    state   <= ARB_CAPT;
                    bus_sel <= 1'b0;
                end
                ARB_CAPT: begin
                    state      <= ARB_IDLE;
                    busy       <= 1'b0;
                    last_owner <= owner;
                    if (owner) begin
                        ack1 <= 1'b1;
                        if (!bus_we) rdata1 <= bus_rdata;
                    end else begin
                        ack0 <= 1'b1;
                        if (!bus_we) rdata0 <= bus_rdata;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    bus_sel <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
